// File: rtl/seq_mult_pkg.sv
// -----------------------------------------------------------------------------
// seq_mult_pkg
// Shared definitions for the sequential shift-add multiplier:
//   state_e  - controller states (IDLE / RUN / DONE)
//   cnt_w()  - iteration-counter width for a given operand width
//   prod_w() - product width for a given operand width
// Optional feature macro used by the design: SEQ_MULT_SIGNED_EN
// -----------------------------------------------------------------------------
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must hold 0..WIDTH (it steps once more on the finishing edge).
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int prod_w(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// -----------------------------------------------------------------------------
// seq_mult_ctrl
// FSM and iteration counter for seq_mult. Accepts an operand pair in IDLE,
// issues exactly WIDTH step strobes in RUN (the last one also flagged as
// finish), then holds DONE until the consumer takes the product.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid_i      operand pair offered
//   out_ready_i     consumer accepts product
//   in_ready_o      high only in IDLE
//   out_valid_o     high only in DONE
//   load_o          capture operands this edge
//   step_o          perform one shift-add iteration this edge
//   finish_o        last iteration; load product this edge
// -----------------------------------------------------------------------------
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid_i,
    input  logic out_ready_i,
    output logic in_ready_o,
    output logic out_valid_o,
    output logic load_o,
    output logic step_o,
    output logic finish_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        load_o      = 1'b0;
        step_o      = 1'b0;
        finish_o    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    load_o  = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                step_o = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                // cnt_q counts completed iterations; this edge is number cnt_q+1.
                if (cnt_q == LAST) begin
                    finish_o = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/seq_mult.sv
// -----------------------------------------------------------------------------
// seq_mult
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one multiplier
// bit per clock. Fixed latency: out_valid rises WIDTH edges after the
// accepting edge. p is held until the next product is loaded.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready operand handshake (in_ready high only in IDLE)
//   a, b              multiplicand / multiplier
//   out_valid/out_ready product handshake (out_valid high only in DONE)
//   p                 product
// Optional feature: define SEQ_MULT_SIGNED_EN for two's-complement operands
// and product (magnitudes are multiplied, the sign is applied at the end).
// -----------------------------------------------------------------------------
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_w(WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     p
);

    localparam int PW = prod_w(WIDTH);

    logic            load, step, finish;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   p_q, p_d;
    logic [PW-1:0]   acc_fin;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] a_mag, b_mag;

    seq_mult_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .out_ready_i (out_ready),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .load_o      (load),
        .step_o      (step),
        .finish_o    (finish)
    );

`ifdef SEQ_MULT_SIGNED_EN
    logic sign_q, sign_d;

    // Most-negative input negates to itself, which read unsigned is 2^(WIDTH-1).
    assign a_mag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    assign b_mag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    assign sign_d = load ? (a[WIDTH-1] ^ b[WIDTH-1]) : sign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sign_q <= 1'b0;
        else     sign_q <= sign_d;
    end
`else
    assign a_mag = a;
    assign b_mag = b;
`endif

    // Accumulator value after the current iteration; on the finishing edge
    // this is the full product, so p is loaded from it directly.
    assign acc_fin = acc_q + (mplier_q[0] ? mcand_q : {PW{1'b0}});

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        p_d      = p_q;
        if (load) begin
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
            acc_d    = '0;
        end else if (step) begin
            acc_d    = acc_fin;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
        if (finish) begin
`ifdef SEQ_MULT_SIGNED_EN
            p_d = sign_q ? (~acc_fin + PW'(1)) : acc_fin;
`else
            p_d = acc_fin;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            p_q      <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            p_q      <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: tb/tb_seq_mult.sv
// -----------------------------------------------------------------------------
// tb_seq_mult
// Directed and exhaustive checks of seq_mult at WIDTH=8 and WIDTH=4.
// Expected products are queued when operands are driven and popped when the
// DUT presents a result. Honours SEQ_MULT_SIGNED_EN for the expected values.
// -----------------------------------------------------------------------------
module tb_seq_mult;

    logic clk, rst;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;

    int checks = 0;
    int errors = 0;

    logic [15:0] q8[$];
    logic [7:0]  q4[$];

    seq_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .p(p8)
    );

    seq_mult #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .p(p4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y);
`ifdef SEQ_MULT_SIGNED_EN
        logic signed [15:0] xs, ys;
        xs = {{8{x[7]}}, x};
        ys = {{8{y[7]}}, y};
        return xs * ys;
`else
        return {8'd0, x} * {8'd0, y};
`endif
    endfunction

    function automatic logic [7:0] model4(input logic [3:0] x, input logic [3:0] y);
`ifdef SEQ_MULT_SIGNED_EN
        logic signed [7:0] xs, ys;
        xs = {{4{x[3]}}, x};
        ys = {{4{y[3]}}, y};
        return xs * ys;
`else
        return {4'd0, x} * {4'd0, y};
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 transaction; stall = DONE cycles with out_ready low.
    task automatic mult8(input logic [7:0] av, input logic [7:0] bv,
                         input logic [15:0] ev, input int stall, input string tag);
        logic [15:0] e;
        int lat;
        chk({tag, ".in_ready_idle"}, 32'(in_ready8), 32'd1);
        a8 = av; b8 = bv; in_valid8 = 1'b1; out_ready8 = (stall == 0);
        q8.push_back(ev);
        step();
        in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 0;
        while (!out_valid8 && lat < 20) begin
            chk({tag, ".in_ready_run"}, 32'(in_ready8), 32'd0);
            step();
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'd8);
        e = q8.pop_front();
        chk({tag, ".p"}, 32'(p8), 32'(e));
        for (int i = 0; i < stall; i++) begin
            in_valid8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
            step();
            chk({tag, ".stall_valid"}, 32'(out_valid8), 32'd1);
            chk({tag, ".stall_p"}, 32'(p8), 32'(e));
            chk({tag, ".stall_in_ready"}, 32'(in_ready8), 32'd0);
        end
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        step();
        chk({tag, ".idle_valid"}, 32'(out_valid8), 32'd0);
        chk({tag, ".idle_in_ready"}, 32'(in_ready8), 32'd1);
        chk({tag, ".p_held"}, 32'(p8), 32'(e));
        out_ready8 = 1'b0;
    endtask

    task automatic mult4(input logic [3:0] av, input logic [3:0] bv);
        logic [7:0] e;
        int lat, stall;
        stall = $urandom_range(0, 2);
        a4 = av; b4 = bv; in_valid4 = 1'b1; out_ready4 = 1'b0;
        q4.push_back(model4(av, bv));
        step();
        in_valid4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        lat = 0;
        while (!out_valid4 && lat < 12) begin
            step();
            lat++;
        end
        chk("w4.latency", 32'(lat), 32'd4);
        e = q4.pop_front();
        chk($sformatf("w4.p a=%h b=%h", av, bv), 32'(p4), 32'(e));
        repeat (stall) step();
        out_ready4 = 1'b1;
        step();
        chk("w4.idle", 32'({out_valid4, in_ready4}), 32'b01);
        out_ready4 = 1'b0;
    endtask

    initial begin
        logic seen;
        rst = 1'b1;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0;
        #1;
        chk("rst.in_ready", 32'(in_ready8), 32'd1);
        chk("rst.out_valid", 32'(out_valid8), 32'd0);
        chk("rst.p", 32'(p8), 32'd0);
        step(); step();
        rst = 1'b0;
        step();
        chk("post_rst.idle", 32'({in_ready8, out_valid8}), 32'b10);

`ifdef SEQ_MULT_SIGNED_EN
        mult8(8'd13,  8'd11,  16'h008F, 0, "s13x11");
        mult8(8'hFD,  8'd5,   16'hFFF1, 0, "m3x5");
        mult8(8'h80,  8'h80,  16'h4000, 0, "m128xm128");
        mult8(8'd127, 8'h80,  16'hC080, 1, "127xm128");
        mult8(8'hFF,  8'hFF,  16'h0001, 0, "m1xm1");
`else
        mult8(8'd13,  8'd11,  16'h008F, 0, "13x11");
        mult8(8'd253, 8'd5,   16'h04F1, 0, "253x5");
        mult8(8'h80,  8'h80,  16'h4000, 0, "128x128");
        mult8(8'd127, 8'h80,  16'h3F80, 1, "127x128");
        mult8(8'd255, 8'd255, 16'hFE01, 0, "255x255");
`endif
        mult8(8'd0, 8'd200, 16'h0000, 0, "0x200");
        mult8(8'd7, 8'd9,   16'h003F, 5, "bp7x9");
        for (int i = 0; i < 6; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom); rb = 8'($urandom);
            mult8(ra, rb, model8(ra, rb), i % 3, "rand");
        end

        // Reset in the middle of a run: no result may appear afterwards.
        a8 = 8'd100; b8 = 8'd3; in_valid8 = 1'b1; out_ready8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        step(); step();
        #2 rst = 1'b1;
        #1;
        chk("midrun_rst.out_valid", 32'(out_valid8), 32'd0);
        chk("midrun_rst.p", 32'(p8), 32'd0);
        chk("midrun_rst.in_ready", 32'(in_ready8), 32'd1);
        step(); step();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid8) seen = 1'b1;
        end
        chk("midrun_rst.no_valid", 32'(seen), 32'd0);
        chk("midrun_rst.p_zero", 32'(p8), 32'd0);
        out_ready8 = 1'b0;
        mult8(8'd6, 8'd7, 16'h002A, 0, "after_rst6x7");

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                mult4(4'(i), 4'(j));
            end
        end

        chk("queues_empty", 32'(q8.size() + q4.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
